// File: rtl/scs8hd_lpflow_pkg.sv
// Shared types and default timing for the lpflow kapwr power sequencer.
// The state enum and per-state output decode live here so every user agrees on them.
package scs8hd_lpflow_pkg;

    localparam int unsigned CNT_W_DEF      = 4;
    localparam int unsigned ISO_DLY_DEF    = 2;
    localparam int unsigned SAVE_DLY_DEF   = 3;
    localparam int unsigned PG_TIMEOUT_DEF = 12;

    typedef enum logic [3:0] {
        ST_ON,
        ST_CLK_OFF,
        ST_ISO,
        ST_SAVE,
        ST_PWR_OFF,
        ST_OFF,
        ST_PWR_ON,
        ST_RESTORE,
        ST_ISO_REL,
        ST_CLK_ON
    } pwrseq_state_t;

    typedef struct packed {
        logic sleep_ack;
        logic clk_en;
        logic iso_en;
        logic ret_save;
        logic ret_restore;
        logic pwr_sw_en;
        logic busy;
    } pwrseq_out_t;

    // Output levels a state holds for its whole residency; registered on entry.
    function automatic pwrseq_out_t state_outputs(input pwrseq_state_t s);
        pwrseq_out_t o;
        o = '0;
        case (s)
            ST_ON: begin
                o.clk_en    = 1'b1;
                o.pwr_sw_en = 1'b1;
            end
            ST_CLK_OFF: begin
                o.pwr_sw_en = 1'b1;
                o.busy      = 1'b1;
            end
            ST_ISO: begin
                o.iso_en    = 1'b1;
                o.pwr_sw_en = 1'b1;
                o.busy      = 1'b1;
            end
            ST_SAVE: begin
                o.iso_en    = 1'b1;
                o.ret_save  = 1'b1;
                o.pwr_sw_en = 1'b1;
                o.busy      = 1'b1;
            end
            ST_PWR_OFF: begin
                o.iso_en    = 1'b1;
                o.busy      = 1'b1;
            end
            ST_OFF: begin
                o.iso_en    = 1'b1;
                o.sleep_ack = 1'b1;
            end
            ST_PWR_ON: begin
                o.iso_en    = 1'b1;
                o.pwr_sw_en = 1'b1;
                o.busy      = 1'b1;
            end
            ST_RESTORE: begin
                o.iso_en      = 1'b1;
                o.ret_restore = 1'b1;
                o.pwr_sw_en   = 1'b1;
                o.busy        = 1'b1;
            end
            ST_ISO_REL: begin
                o.pwr_sw_en = 1'b1;
                o.busy      = 1'b1;
            end
            ST_CLK_ON: begin
                o.clk_en    = 1'b1;
                o.pwr_sw_en = 1'b1;
                o.busy      = 1'b1;
            end
            default: begin
                o.clk_en    = 1'b1;
                o.pwr_sw_en = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/scs8hd_lpflow_kapwr_pwrseq_if.sv
// Control/status bundle between the power manager (master) and the sequencer (slave).
// sleep_req/sleep_ack are a level request/acknowledge: the master holds sleep_req and
// the island is off exactly while sleep_ack=1; dropping sleep_req requests wake.
interface scs8hd_lpflow_kapwr_pwrseq_if;

    logic sleep_req;
    logic pwr_good;
    logic sleep_ack;
    logic clk_en;
    logic iso_en;
    logic ret_save;
    logic ret_restore;
    logic pwr_sw_en;
    logic busy;
    logic err;

    modport master (
        output sleep_req,
        output pwr_good,
        input  sleep_ack,
        input  clk_en,
        input  iso_en,
        input  ret_save,
        input  ret_restore,
        input  pwr_sw_en,
        input  busy,
        input  err
    );

    modport slave (
        input  sleep_req,
        input  pwr_good,
        output sleep_ack,
        output clk_en,
        output iso_en,
        output ret_save,
        output ret_restore,
        output pwr_sw_en,
        output busy,
        output err
    );

endinterface

// File: rtl/scs8hd_lpflow_dly_cnt.sv
// Loadable down-counter with zero flag; parks at zero until reloaded.
module scs8hd_lpflow_dly_cnt
    import scs8hd_lpflow_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/scs8hd_lpflow_kapwr_pwrseq.sv
// Always-on power-down/wake sequencer for a switchable vpwr island: orders clock stop,
// isolation, retention save and switch-off, and the reverse on wake.
module scs8hd_lpflow_kapwr_pwrseq
    import scs8hd_lpflow_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned ISO_DLY    = ISO_DLY_DEF,
    parameter int unsigned SAVE_DLY   = SAVE_DLY_DEF,
    parameter int unsigned PG_TIMEOUT = PG_TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    scs8hd_lpflow_kapwr_pwrseq_if.slave  bus,
    output pwrseq_state_t                state_dbg,
    output logic [CNT_W-1:0]             cnt_dbg
);

    pwrseq_state_t    state;
    pwrseq_state_t    nxt_state;
    pwrseq_out_t      out_q;
    logic             err_q;
    logic             abort_q;
    logic             cnt_load;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_val;

    // Timed states leave only when the counter reaches zero; a clock-off request that
    // was withdrawn at any point is remembered in abort_q and taken at that exit.
    always_comb begin
        nxt_state = state;
        case (state)
            ST_ON:      if (bus.sleep_req) nxt_state = ST_CLK_OFF;
            ST_CLK_OFF: if (cnt_zero) nxt_state = (abort_q || !bus.sleep_req) ? ST_CLK_ON : ST_ISO;
            ST_ISO:     if (cnt_zero) nxt_state = ST_SAVE;
            ST_SAVE:    if (cnt_zero) nxt_state = ST_PWR_OFF;
            ST_PWR_OFF: if (cnt_zero) nxt_state = ST_OFF;
            ST_OFF:     if (!bus.sleep_req) nxt_state = ST_PWR_ON;
            ST_PWR_ON:  if (bus.pwr_good) nxt_state = ST_RESTORE;
            ST_RESTORE: if (cnt_zero) nxt_state = ST_ISO_REL;
            ST_ISO_REL: if (cnt_zero) nxt_state = ST_CLK_ON;
            ST_CLK_ON:  if (cnt_zero) nxt_state = ST_ON;
            default:    nxt_state = ST_ON;
        endcase
    end

    // Residency minus one is loaded so the state lasts exactly its delay in cycles.
    always_comb begin
        cnt_load_val = '0;
        case (nxt_state)
            ST_CLK_OFF, ST_ISO, ST_ISO_REL: cnt_load_val = CNT_W'(ISO_DLY - 1);
            ST_SAVE:                        cnt_load_val = CNT_W'(SAVE_DLY - 1);
            ST_PWR_ON:                      cnt_load_val = CNT_W'(PG_TIMEOUT - 1);
            default:                        cnt_load_val = '0;
        endcase
    end

    assign cnt_load = (nxt_state != state);

    scs8hd_lpflow_dly_cnt #(
        .CNT_W (CNT_W)
    ) u_dly_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_ON;
            out_q   <= state_outputs(ST_ON);
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= nxt_state;
            out_q   <= state_outputs(nxt_state);
            err_q   <= err_q | ((state == ST_PWR_ON) && !bus.pwr_good && cnt_zero);
            abort_q <= (nxt_state == ST_CLK_OFF) && (abort_q || !bus.sleep_req);
        end
    end

    assign bus.sleep_ack   = out_q.sleep_ack;
    assign bus.clk_en      = out_q.clk_en;
    assign bus.iso_en      = out_q.iso_en;
    assign bus.ret_save    = out_q.ret_save;
    assign bus.ret_restore = out_q.ret_restore;
    assign bus.pwr_sw_en   = out_q.pwr_sw_en;
    assign bus.busy        = out_q.busy;
    assign bus.err         = err_q;

    assign state_dbg = state;
    assign cnt_dbg   = cnt_val;

endmodule

// File: tb/tb_scs8hd_lpflow_kapwr_pwrseq.sv
// Bench for the kapwr power sequencer: directed timeline scenarios plus a randomised
// run against a phase/duration reference model, with invariant checks every cycle.
module tb_scs8hd_lpflow_kapwr_pwrseq;
    import scs8hd_lpflow_pkg::*;

    localparam int ISO_DLY    = 2;
    localparam int SAVE_DLY   = 3;
    localparam int PG_TIMEOUT = 12;

    localparam int P_ON = 0, P_CLK_OFF = 1, P_ISO = 2, P_SAVE = 3, P_PWR_OFF = 4;
    localparam int P_OFF = 5, P_PWR_ON = 6, P_RESTORE = 7, P_ISO_REL = 8, P_CLK_ON = 9;

    logic          clk = 1'b0;
    logic          reset;
    pwrseq_state_t state_dbg;
    logic [3:0]    cnt_dbg;

    int compared   = 0;
    int mismatched = 0;
    bit inv_on     = 1'b0;

    int m_ph;
    int m_t;
    bit m_abort;
    bit m_err;

    scs8hd_lpflow_kapwr_pwrseq_if bus ();

    scs8hd_lpflow_kapwr_pwrseq dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg),
        .cnt_dbg   (cnt_dbg)
    );

    always #5 clk = ~clk;

    // {sleep_ack, clk_en, iso_en, ret_save, ret_restore, pwr_sw_en, busy, err}
    function automatic logic [7:0] obs();
        return {bus.sleep_ack, bus.clk_en, bus.iso_en, bus.ret_save,
                bus.ret_restore, bus.pwr_sw_en, bus.busy, bus.err};
    endfunction

    function automatic logic [7:0] pack_exp(bit ack, bit ce, bit iso, bit sv,
                                            bit rs, bit pw, bit bz, bit er);
        return {ack, ce, iso, sv, rs, pw, bz, er};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the sequence is a list of phases, each held for a fixed
    // number of cycles; t counts cycles already spent in the current phase.
    function automatic int dur(int p);
        case (p)
            P_CLK_OFF, P_ISO, P_ISO_REL: return ISO_DLY;
            P_SAVE:                      return SAVE_DLY;
            P_PWR_OFF, P_RESTORE, P_CLK_ON: return 1;
            default:                     return 0;
        endcase
    endfunction

    function automatic logic [7:0] m_out();
        bit iso_closed;
        iso_closed = (m_ph >= P_ISO) && (m_ph <= P_RESTORE);
        return pack_exp(m_ph == P_OFF, (m_ph == P_ON) || (m_ph == P_CLK_ON), iso_closed,
                        m_ph == P_SAVE, m_ph == P_RESTORE,
                        !((m_ph == P_PWR_OFF) || (m_ph == P_OFF)),
                        !((m_ph == P_ON) || (m_ph == P_OFF)), m_err);
    endfunction

    task automatic model_step(input bit sr, input bit pg, input bit rst);
        int nx;
        if (rst) begin
            m_ph = P_ON; m_t = 0; m_abort = 1'b0; m_err = 1'b0;
            return;
        end
        m_t++;
        nx = m_ph;
        case (m_ph)
            P_ON: if (sr) nx = P_CLK_OFF;
            P_CLK_OFF: begin
                if (!sr) m_abort = 1'b1;
                if (m_t >= ISO_DLY) nx = m_abort ? P_CLK_ON : P_ISO;
            end
            P_OFF: if (!sr) nx = P_PWR_ON;
            P_PWR_ON: begin
                if (pg) nx = P_RESTORE;
                else if (m_t >= PG_TIMEOUT) m_err = 1'b1;
            end
            default: if (m_t >= dur(m_ph)) nx = (m_ph == P_CLK_ON) ? P_ON : m_ph + 1;
        endcase
        if (nx != m_ph) begin
            m_ph = nx; m_t = 0; m_abort = 1'b0;
        end
    endtask

    // Safety invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (inv_on) begin
            compared++;
            a_iso_when_off: assert (bus.pwr_sw_en || bus.iso_en) else begin
                mismatched++;
                $display("FAIL inv_iso_when_off t=%0t pwr_sw_en=%b iso_en=%b (iso_en must be 1)",
                         $time, bus.pwr_sw_en, bus.iso_en);
            end
            compared++;
            a_clk_when_iso: assert (!(bus.iso_en && bus.clk_en)) else begin
                mismatched++;
                $display("FAIL inv_clk_when_iso t=%0t iso_en=%b clk_en=%b (clk_en must be 0)",
                         $time, bus.iso_en, bus.clk_en);
            end
            compared++;
            a_ret_excl: assert (!(bus.ret_save && bus.ret_restore)) else begin
                mismatched++;
                $display("FAIL inv_ret_excl t=%0t ret_save=%b ret_restore=%b (not both 1)",
                         $time, bus.ret_save, bus.ret_restore);
            end
        end
    end

    task automatic test_reset();
        logic [7:0] got;
        reset = 1'b1; bus.sleep_req = 1'b0; bus.pwr_good = 1'b0;
        tick(); tick();
        reset = 1'b0;
        got = obs();
        compared++;
        if (got !== pack_exp(0, 1, 0, 0, 0, 1, 0, 0)) begin
            mismatched++;
            $display("FAIL reset_outputs got=%b exp=%b", got, pack_exp(0, 1, 0, 0, 0, 1, 0, 0));
        end
        compared++;
        if (state_dbg !== ST_ON) begin
            mismatched++;
            $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_ON);
        end
        compared++;
        if (cnt_dbg !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_counter got=%0d exp=0", cnt_dbg);
        end
        inv_on = 1'b1;
    endtask

    task automatic test_sleep();
        logic [7:0] got, exp;
        bus.sleep_req = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            got = obs();
            exp = pack_exp(k >= 9, 0, k >= 3, (k >= 5) && (k <= 7), 0, k < 8, k <= 8, 0);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL sleep_cycle%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_wake();
        logic [7:0] got, exp;
        bus.pwr_good  = 1'b0;
        bus.sleep_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) bus.pwr_good = 1'b1;
            tick();
            got = obs();
            exp = pack_exp(0, k >= 8, k < 6, 0, k == 5, 1, k <= 8, 0);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL wake_cycle%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] got, exp;
        for (int k = 1; k <= 6; k++) begin
            bus.sleep_req = (k == 1);
            tick();
            got = obs();
            exp = pack_exp(0, !((k == 1) || (k == 2)), 0, 0, 0, 1, k <= 3, 0);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL glitch_cycle%0d got=%b exp=%b", k, got, exp);
            end
        end
        bus.sleep_req = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] got, exp;
        int waited;
        bus.pwr_good  = 1'b0;
        bus.sleep_req = 1'b1;
        waited = 0;
        while ((bus.sleep_ack !== 1'b1) && (waited < 20)) begin
            tick();
            waited++;
        end
        compared++;
        if (bus.sleep_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_reach_off sleep_ack=%b after %0d cycles exp=1", bus.sleep_ack, waited);
        end
        bus.sleep_req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            got = obs();
            exp = pack_exp(0, 0, 1, 0, 0, 1, 1, k >= 13);
            if (k == 12) begin
                got[0] = 1'b0;
                exp[0] = 1'b0;
            end
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL timeout_pwr_on_cycle%0d got=%b exp=%b", k, got, exp);
            end
        end
        bus.pwr_good = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            got = obs();
            exp = pack_exp(0, k >= 4, k < 2, 0, k == 1, 1, k <= 4, 1);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL timeout_wake_cycle%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        bus.sleep_req = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        compared++;
        if ((state_dbg !== ST_SAVE) || (bus.ret_save !== 1'b1)) begin
            mismatched++;
            $display("FAIL reset_mid_in_save state=%0d ret_save=%b exp state=%0d ret_save=1",
                     state_dbg, bus.ret_save, ST_SAVE);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.sleep_req = 1'b0;
        got = obs();
        compared++;
        if (got !== pack_exp(0, 1, 0, 0, 0, 1, 0, 0)) begin
            mismatched++;
            $display("FAIL reset_mid_outputs got=%b exp=%b", got, pack_exp(0, 1, 0, 0, 0, 1, 0, 0));
        end
        compared++;
        if (state_dbg !== ST_ON) begin
            mismatched++;
            $display("FAIL reset_mid_state got=%0d exp=%0d", state_dbg, ST_ON);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        bit glitch;
        glitch = 1'b0;
        reset = 1'b1; bus.sleep_req = 1'b0; bus.pwr_good = 1'b0;
        model_step(1'b0, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if (glitch) begin
                bus.sleep_req = ~bus.sleep_req;
                glitch = 1'b0;
            end else if ($urandom_range(0, 11) == 0) begin
                bus.sleep_req = ~bus.sleep_req;
                glitch = ($urandom_range(0, 2) == 0);
            end
            bus.pwr_good = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 599) == 0);
            model_step(bus.sleep_req, bus.pwr_good, reset);
            tick();
            got = obs();
            exp = m_out();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL random_cycle%0d got=%b exp=%b", n, got, exp);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sleep();
        test_wake();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_random();
        inv_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
